conv3x3_window_feeder: RTL
==========================

# conv3x3_window_feeder

Streams a raster-order 8-bit ifmap frame in and emits every 3x3 convolution window as a packed 72-bit word, one per accepted handshake. Sits directly upstream of the PE tensor and drives one 72-bit ifmap lane. It is the producer of the window format the PE kernel consumes. Valid (unpadded) convolution only, stride 1 by default.

## Interface
- IMG_W, 8: frame width in pixels; legal range 3..1024.
- IMG_H, 8: frame height in pixels; legal range 3..1024.
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a frame when idle.
- pix_in  in  8  input pixel, unsigned.
- pix_valid  in  1  pix_in is valid.
- pix_ready  out  1  block accepts pix_in this cycle.
- win_out  out  72  3x3 window; byte k = 3*r + c at bits [8k+7:8k]; r = row offset 0..2 (top first), c = column offset 0..2 (left first).
- win_valid  out  1  win_out is valid.
- win_ready  in  1  downstream consumes win_out this cycle.
- busy  out  1  high in RUN and DRAIN.
- frame_done  out  1  one-cycle pulse after the last window of a frame is consumed.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start; clears the row and col counters.
  - RUN -> DRAIN when the pixel at (IMG_H-1, IMG_W-1) is accepted.
  - DRAIN -> IDLE when win_valid is low or the final window is consumed. frame_done pulses on that cycle.
- start is ignored in RUN and DRAIN.
- Pixel accept: pix_valid && pix_ready.
  - pix_ready = (state == RUN) && (!win_valid || win_ready).
  - pix_in is don't-care when no accept occurs.
- On accept:
  - Pixel enters a 3x3 register array. Column shift; the new pixel goes to row 2, column 2.
  - Rows 0 and 1 of the new column come from two IMG_W-deep line buffers holding rows y-2 and y-1 at the same column.
  - The line buffers write the pixel and the row-1 value in place.
  - col increments and wraps at IMG_W-1 to 0 with row++.
- Window emit on accept when row >= 2 && col >= 2.
  - The register array is loaded into win_out and win_valid is set.
  - Columns left over from the previous row never appear in an emitted window, because the col >= 2 gate guarantees three fresh columns.
- win_valid/win_out hold stable until win_ready. A window consume and a new emit in the same cycle is legal (back-to-back).
- Windows per frame: (IMG_H-2)*(IMG_W-2), emitted in raster order of the window's top-left corner.
- No arithmetic beyond counters. Counter width = clog2(max(IMG_W, IMG_H)).

## Timing
- Reset values: pix_ready 0, win_valid 0, win_out 0, busy 0, frame_done 0, state IDLE, counters 0. Line buffer contents are not reset.
- Reset mid-frame aborts the frame immediately: the pending window is dropped and no frame_done is issued.
- Latency: win_valid asserts the cycle after the accept of the completing pixel.
- pix_ready rises the cycle after start.
- Throughput: one pixel per cycle with win_ready tied high.
- Backpressure: a held window stalls input and creates no bubble beyond the stall.
- rst has priority over start when both are asserted in the same cycle.

## Configuration
- STRIDE2_EN defined: stride-2 emission.
  - Emit only when row >= 2 && col >= 2 && row[0] == 0 && col[0] == 0.
  - Windows per frame: ((IMG_H-3)/2+1)*((IMG_W-3)/2+1).
  - Line buffers and handshake are unchanged.
- STRIDE2_EN undefined: stride 1 as described above.

## Structure
- Package conv3x3_pkg holds:
  - PIX_W = 8, WIN_TAPS = 9, WIN_W = 72;
  - FSM state enum {IDLE, RUN, DRAIN};
  - a function packing a 3x3 tap array into 72 bits.
- Sub-module window_line_buffer: an IMG_W-deep, 8-bit, single-clock delay line with a read-then-write at a shared address (col). Instantiated twice.

## Test plan
- IMG_W = IMG_H = 4, pixels 0..15, win_ready = 1 -> exactly 4 windows.
  - First window bytes 0..8 = {0,1,2,4,5,6,8,9,10}.
  - Last window = {5,6,7,9,10,11,13,14,15}.
  - frame_done pulses once.
- Same frame, win_ready low for 5 cycles on window 2 -> win_out stable and pix_ready low throughout; all 4 windows correct; total pixels accepted = 16.
- IMG_W = 8, IMG_H = 3, pixel = 10*row + col -> 6 windows. Window 0 row 0 = {0,1,2}; window 5 row 2 = {25,26,27}. No window mixes rows.
- rst asserted after 7 pixels accepted -> the next cycle shows all outputs at reset values. A new start and full frame then yields correct windows.
- start pulsed during RUN -> ignored; window sequence identical to the undisturbed run.
- STRIDE2_EN, IMG_W = IMG_H = 5, pixels 0..24 -> 4 windows with top-left pixels 0, 2, 10, 12.

Source files
------------

// File: rtl/conv3x3_pkg.sv
// Shared types and helpers for the 3x3 window feeder: pixel/window widths,
// FSM state encoding and the tap-array to window-word packing function.
package conv3x3_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN_TAPS = 9;
  localparam int WIN_W    = PIX_W * WIN_TAPS;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef logic [PIX_W-1:0] tap_t;

  // Byte k = 3*r + c, row 0 is the top row and column 0 the leftmost.
  function automatic logic [WIN_W-1:0] pack_window(input tap_t taps [3][3]);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        w[PIX_W*(3*r+c) +: PIX_W] = taps[r][c];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/window_line_buffer.sv
// One image row of delay: combinational read of the old value at addr,
// overwritten with din on the same clock edge when we is high.
module window_line_buffer
  import conv3x3_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

endmodule

// File: rtl/conv3x3_window_feeder.sv
// Raster-order pixel stream in, packed 3x3 valid-convolution windows out.
// Define STRIDE2_EN for stride-2 window emission (default is stride 1).
module conv3x3_window_feeder
  import conv3x3_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [WIN_W-1:0] win_out,
  output logic             win_valid,
  input  logic             win_ready,
  output logic             busy,
  output logic             frame_done
);

  localparam int MAXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CW   = $clog2(MAXD);
  localparam int LAW  = $clog2(IMG_W);

  state_t           state, state_nx;
  logic [CW-1:0]    row, col;
  tap_t             taps    [3][3];
  tap_t             taps_nx [3][3];
  logic [PIX_W-1:0] lb0_q, lb1_q;
  logic             accept, emit, col_last, row_last;

  assign pix_ready = (state == RUN) && (!win_valid || win_ready);
  assign accept    = pix_valid && pix_ready;
  assign busy      = (state != IDLE);
  assign col_last  = (col == CW'(IMG_W-1));
  assign row_last  = (row == CW'(IMG_H-1));

`ifdef STRIDE2_EN
  assign emit = accept && (row >= CW'(2)) && (col >= CW'(2)) && !row[0] && !col[0];
`else
  assign emit = accept && (row >= CW'(2)) && (col >= CW'(2));
`endif

  // lb0 holds row y-2, lb1 holds row y-1; on accept each row ages by one.
  window_line_buffer #(.DEPTH(IMG_W), .AW(LAW)) u_lb0 (
    .clk  (clk),
    .we   (accept),
    .addr (col[LAW-1:0]),
    .din  (lb1_q),
    .dout (lb0_q)
  );

  window_line_buffer #(.DEPTH(IMG_W), .AW(LAW)) u_lb1 (
    .clk  (clk),
    .we   (accept),
    .addr (col[LAW-1:0]),
    .din  (pix_in),
    .dout (lb1_q)
  );

  always_comb begin
    taps_nx = taps;
    for (int unsigned r = 0; r < 3; r++) begin
      taps_nx[r][0] = taps[r][1];
      taps_nx[r][1] = taps[r][2];
    end
    taps_nx[0][2] = lb0_q;
    taps_nx[1][2] = lb1_q;
    taps_nx[2][2] = pix_in;
  end

  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN:   if (accept && col_last && row_last) state_nx = DRAIN;
      DRAIN: begin
        if (!win_valid || win_ready) begin
          state_nx   = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      win_valid <= 1'b0;
      win_out   <= '0;
    end else begin
      if (state == IDLE && start) begin
        row <= '0;
        col <= '0;
      end else if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // Overwriting a window being consumed this cycle is the back-to-back case.
      if (emit) begin
        win_valid <= 1'b1;
        win_out   <= pack_window(taps_nx);
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) taps <= taps_nx;
  end

endmodule
